// File: rtl/serpent_encrypt_iter.sv
// Iterative Serpent-128 encryptor: one round per clock, round keys
// fetched one at a time through key_idx/round_key.
// Ports: clk, rst_n; in_valid/in_ready/in_data plaintext side;
// key_idx/round_key key lookup; out_valid/out_ready/out_data
// ciphertext side; busy high while a block is in flight.
module serpent_encrypt_iter #(
  parameter int ROUNDS = 32,
  parameter int KIDX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  localparam logic [KIDX_W-1:0] LAST = KIDX_W'(ROUNDS);
  localparam logic [KIDX_W-1:0] FINS = KIDX_W'(ROUNDS - 1);

  // S-box n, entry v lives in nibble v (entry 0 in the low nibble)
  localparam logic [63:0] S0 = 64'hC907_24DE_B56A_1F83;
  localparam logic [63:0] S1 = 64'h43D6_8EB1_A509_72CF;
  localparam logic [63:0] S2 = 64'h25B0_4E1D_FAC3_9768;
  localparam logic [63:0] S3 = 64'hE57A_421D_369C_8BF0;
  localparam logic [63:0] S4 = 64'hD7E9_A452_6B0C_38F1;
  localparam logic [63:0] S5 = 64'h176D_8E30_C9A4_B25F;
  localparam logic [63:0] S6 = 64'h0A3D_F19E_B648_5C27;
  localparam logic [63:0] S7 = 64'h6539_AC47_B28E_0FD1;

  fsm_e              cs, ns;
  logic [KIDX_W-1:0] round;
  logic [127:0]      st;
  logic              vld_q;
  logic [127:0]      t_x, t_s, t_l, nxt;

  function automatic logic [3:0] sb4(
    input logic [2:0] n,
    input logic [3:0] v
  );
    logic [63:0] t;
    unique case (n)
      3'd0: t = S0;
      3'd1: t = S1;
      3'd2: t = S2;
      3'd3: t = S3;
      3'd4: t = S4;
      3'd5: t = S5;
      3'd6: t = S6;
      3'd7: t = S7;
    endcase
    return t[{v, 2'b00} +: 4];
  endfunction

  // bit i of X0..X3 forms one 4-bit S-box input, X0 as LSB
  function automatic logic [127:0] sbox(
    input logic [2:0]   n,
    input logic [127:0] x
  );
    logic [127:0] y;
    logic [3:0]   o;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      o = sb4(n, {x[96+i], x[64+i], x[32+i], x[i]});
      y[i]    = o[0];
      y[32+i] = o[1];
      y[64+i] = o[2];
      y[96+i] = o[3];
    end
    return y;
  endfunction

  function automatic logic [31:0] rol(
    input logic [31:0] x,
    input int          n
  );
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] lt(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = x;
    x0 = rol(x0, 13);
    x2 = rol(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rol(x1, 1);
    x3 = rol(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rol(x0, 5);
    x2 = rol(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  // one round: key mix, S-box layer, LT; the last two rounds
  // drop the LT and the S-box layer respectively
  always_comb begin
    t_x = st ^ round_key;
    t_s = sbox(round[2:0], t_x);
    t_l = lt(t_s);
    nxt = t_l;
    if (round == LAST)
      nxt = t_x;
    else if (round == FINS)
      nxt = t_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cs <= IDLE;
    else
      cs <= ns;
  end

  always_comb begin
    ns = cs;
    unique case (cs)
      IDLE: if (in_valid) ns = RUN;
      RUN:  if (round == LAST) ns = DONE;
      DONE: if (vld_q && out_ready) ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (cs == IDLE);
    busy      = (cs != IDLE);
    key_idx   = (cs == RUN) ? round : '0;
    out_valid = vld_q;
    out_data  = vld_q ? st : '0;
  end

  // out_valid rises one cycle into DONE and drops on the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round <= '0;
      st    <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= (cs == DONE) && !(vld_q && out_ready);
      unique case (cs)
        IDLE: begin
          round <= '0;
          if (in_valid) st <= in_data;
        end
        RUN: begin
          st    <= nxt;
          round <= (round == LAST) ? '0 : round + 1'b1;
        end
        default: round <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_serpent_encrypt_iter.sv
// Bench for serpent_encrypt_iter: ciphertext is decrypted by an
// inverse model and compared with the queued plaintext.
module tb_serpent_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [5:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  logic [127:0] rk [0:32];
  logic [127:0] q [$];
  logic [3:0]   isb [8][16];
  int           checks = 0;
  int           fails = 0;

  localparam int SB [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  serpent_encrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign round_key = (key_idx <= 6'd32) ? rk[key_idx] : '0;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] inv_sb(input int n, input logic [127:0] x);
    logic [127:0] y;
    logic [3:0]   o;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      o = isb[n][{x[96+i], x[64+i], x[32+i], x[i]}];
      y[i]    = o[0];
      y[32+i] = o[1];
      y[64+i] = o[2];
      y[96+i] = o[3];
    end
    return y;
  endfunction

  function automatic logic [127:0] inv_lt(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = x;
    x2 = ror(x2, 22);
    x0 = ror(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = ror(x3, 7);
    x1 = ror(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = ror(x2, 3);
    x0 = ror(x0, 13);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] decrypt(input logic [127:0] c);
    logic [127:0] s;
    s = c ^ rk[32];
    s = inv_sb(7, s) ^ rk[31];
    for (int r = 30; r >= 0; r--) begin
      s = inv_lt(s);
      s = inv_sb(r % 8, s) ^ rk[r];
    end
    return s;
  endfunction

  task automatic abort(input string tag);
    $display("FAIL %s timeout", tag);
    fails++;
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "bench stopped");
  endtask

  task automatic send(input logic [127:0] pt);
    int n;
    @(negedge clk);
    in_data  = pt;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) abort("in_ready");
    end
    @(posedge clk);
    q.push_back(pt);
    #1;
    in_valid = 1'b0;
    in_data  = rnd128();
  endtask

  task automatic collect(input int hold, input bit mon, input int inj);
    int           k;
    logic [127:0] ct;
    logic [127:0] pt;
    k = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (mon) begin
        chk("key_idx", 128'(key_idx), (k <= 32) ? 128'(k) : '0);
        chk("busy_run", 128'(busy), 128'(1));
      end
      if (inj >= 0 && k == inj) begin
        chk("in_ready_run", 128'(in_ready), '0);
        in_valid = 1'b1;
        in_data  = rnd128();
      end
      if (inj >= 0 && k == inj + 1) in_valid = 1'b0;
      k++;
      if (k > 60) abort("out_valid");
    end
    if (mon) chk("latency", 128'(k), 128'(34));
    ct = out_data;
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_data", out_data, ct);
      chk("hold_in_ready", 128'(in_ready), '0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    pt = q.pop_front();
    chk("roundtrip", decrypt(ct), pt);
    if (mon) begin
      @(negedge clk);
      chk("in_ready_after", 128'(in_ready), 128'(1));
      chk("busy_after", 128'(busy), '0);
    end
  endtask

  task automatic new_keys();
    for (int i = 0; i <= 32; i++) rk[i] = rnd128();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), '0);
    chk({tag, "_busy"}, 128'(busy), '0);
    chk({tag, "_key_idx"}, 128'(key_idx), '0);
    chk({tag, "_out_data"}, out_data, '0);
  endtask

  initial begin
    int k;
    for (int n = 0; n < 8; n++)
      for (int v = 0; v < 16; v++)
        isb[n][SB[n][v]] = 4'(v);
    for (int i = 0; i <= 32; i++) rk[i] = '0;

    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // all-zero keys and plaintext, full timing monitor
    send('0);
    collect(0, 1'b1, -1);

    // random block, ciphertext held 20 cycles
    new_keys();
    send(rnd128());
    collect(20, 1'b1, -1);

    // new data offered mid-run is ignored
    send(rnd128());
    collect(0, 1'b1, 10);

    // reset in the middle of RUN
    new_keys();
    send(rnd128());
    for (k = 0; k < 17; k++) @(negedge clk);
    chk("pre_rst_key_idx", 128'(key_idx), 128'(16));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    void'(q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("no_stale_valid", 128'(out_valid), '0);
    end
    send(rnd128());
    collect(0, 1'b1, -1);

    // bulk random plaintext and keys
    for (int it = 0; it < 1000; it++) begin
      new_keys();
      send(rnd128());
      collect(it % 3, (it % 100) == 0, -1);
    end

    chk("queue_empty", 128'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
